// File: rtl/psum_ofifo.sv
// Column-lane output FIFO behind the last mac_row: per-lane write pointers absorb the diagonal
// skew, one shared read pointer pops a complete aligned row once every lane holds data.
module psum_ofifo #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [col-1:0]           wr,
   input  logic [col*psum_bw-1:0]   in,
   input  logic                     rd,
   output logic [col*psum_bw-1:0]   out,
   output logic                     o_valid,
   output logic                     o_ready,
   output logic                     o_full,
   output logic                     o_overflow
);

   localparam int ptr_w = $clog2(depth);
   localparam logic [ptr_w:0] ptr_one = {{ptr_w{1'b0}}, 1'b1};

   logic [ptr_w:0]       wptr [col];
   logic [ptr_w:0]       rptr;
   logic [psum_bw-1:0]   mem  [col][depth];

   logic [col-1:0]       lane_empty;
   logic [col-1:0]       lane_full;
   logic [col-1:0]       wr_ok;
   logic                 pop;
   logic                 ovf_hit;

   always_comb begin
      lane_empty = '0;
      lane_full  = '0;
      for (int i = 0; i < col; i++) begin
         lane_empty[i] = (wptr[i] == rptr);
         lane_full[i]  = (wptr[i][ptr_w-1:0] == rptr[ptr_w-1:0]) &&
                         (wptr[i][ptr_w] != rptr[ptr_w]);
      end
   end

   assign o_valid = ~|lane_empty;
   assign o_full  = |lane_full;
   assign o_ready = ~o_full;
   assign pop     = rd & o_valid;

   // A pop on the same edge frees the slot, so a write into a full lane is still accepted.
   assign wr_ok   = wr & (~lane_full | {col{pop}});
   assign ovf_hit = (|(wr & lane_full)) & ~pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rptr       <= '0;
         o_overflow <= 1'b0;
         for (int i = 0; i < col; i++) begin
            wptr[i] <= '0;
         end
      end else begin
         if (pop) begin
            rptr <= rptr + ptr_one;
         end
         if (ovf_hit) begin
            o_overflow <= 1'b1;
         end
         for (int i = 0; i < col; i++) begin
            if (wr_ok[i]) begin
               wptr[i] <= wptr[i] + ptr_one;
            end
         end
      end
   end

   // Storage is deliberately left unreset; out is masked until every lane holds data.
   always_ff @(posedge clk) begin
      for (int i = 0; i < col; i++) begin
         if (wr_ok[i]) begin
            mem[i][wptr[i][ptr_w-1:0]] <= in[i*psum_bw +: psum_bw];
         end
      end
   end

   always_comb begin
      out = '0;
      if (o_valid) begin
         for (int i = 0; i < col; i++) begin
            out[i*psum_bw +: psum_bw] = mem[i][rptr[ptr_w-1:0]];
         end
      end
   end

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: directed scenarios plus randomized traffic against a per-lane
// queue model of the collector.
module tb_psum_ofifo;

   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic [COL-1:0]   wr;
   logic [COL*BW-1:0] in;
   logic             rd;
   logic [COL*BW-1:0] out;
   logic             o_valid;
   logic             o_ready;
   logic             o_full;
   logic             o_overflow;

   int total = 0;
   int bad   = 0;

   logic [BW-1:0] q [COL][$];
   bit            ovf_m;

   always #5 clk = ~clk;

   psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
      .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
      .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full), .o_overflow(o_overflow)
   );

   function automatic bit m_valid();
      for (int i = 0; i < COL; i++) if (q[i].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_full();
      for (int i = 0; i < COL; i++) if (q[i].size() == DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [COL*BW-1:0] m_out();
      logic [COL*BW-1:0] v = '0;
      if (m_valid()) for (int i = 0; i < COL; i++) v[i*BW +: BW] = q[i][0];
      return v;
   endfunction

   function automatic logic [COL*BW-1:0] mk_row(input logic [BW-1:0] base, input int step);
      logic [COL*BW-1:0] v = '0;
      for (int i = 0; i < COL; i++) v[i*BW +: BW] = base + BW'(i * step);
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < COL; i++) q[i].delete();
      ovf_m = 1'b0;
   endtask

   // Pop is decided on the contents before the edge; a write then needs a free slot.
   task automatic model_step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
      bit p;
      p = r && m_valid();
      for (int i = 0; i < COL; i++) begin
         if (p) void'(q[i].pop_front());
         if (w[i]) begin
            if (q[i].size() < DEPTH) q[i].push_back(d[i*BW +: BW]);
            else ovf_m = 1'b1;
         end
      end
   endtask

   task automatic tick(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
      @(negedge clk);
      wr = w; in = d; rd = r;
      @(posedge clk);
      model_step(w, d, r);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      wr = '0; in = '0; rd = 1'b0;
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
      total++; if (o_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", o_full); end
      total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", o_overflow); end
      total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
      @(negedge clk);
      reset = 1'b1;
      model_clear();
   endtask

   task automatic test_single_row();
      logic [COL*BW-1:0] row;
      row = mk_row(16'h0100, 1);
      tick(8'hFF, row, 1'b0);
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", o_valid); end
      total++; if (out !== row) begin bad++; $display("FAIL single_out got=%h want=%h", out, row); end
      tick(8'h00, '0, 1'b1);
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b want=0", o_valid); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL single_pop_ready got=%b want=1", o_ready); end
   endtask

   task automatic test_skew();
      logic [COL*BW-1:0] row;
      row = mk_row(16'h0000, 3);
      for (int i = 0; i < COL; i++) begin
         tick(COL'(1) << i, row, 1'b0);
         if (i < COL - 1) begin
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL skew_early_valid cyc=%0d got=%b want=0", i, o_valid); end
         end
      end
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL skew_valid got=%b want=1", o_valid); end
      total++; if (out !== row) begin bad++; $display("FAIL skew_out got=%h want=%h", out, row); end
      tick(8'h00, '0, 1'b1);
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL skew_drain got=%b want=0", o_valid); end
   endtask

   task automatic test_fill_overflow();
      apply_reset();
      for (int r = 0; r < DEPTH; r++) tick(8'hFF, mk_row(BW'(r << 8), 1), 1'b0);
      total++; if (o_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", o_full); end
      total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", o_ready); end
      total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b want=0", o_overflow); end
      tick(8'hFF, mk_row(16'hDEAD, 0), 1'b0);
      total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b want=1", o_overflow); end
      for (int r = 0; r < DEPTH; r++) begin
         total++; if (out !== mk_row(BW'(r << 8), 1)) begin bad++; $display("FAIL fill_order row=%0d got=%h want=%h", r, out, mk_row(BW'(r << 8), 1)); end
         tick(8'h00, '0, 1'b1);
      end
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fill_no_extra got=%b want=0", o_valid); end
      total++; if (o_overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf_sticky got=%b want=1", o_overflow); end
   endtask

   task automatic test_full_rdwr();
      apply_reset();
      for (int r = 0; r < DEPTH; r++) tick(8'hFF, mk_row(BW'(r * 16), 1), 1'b0);
      tick(8'hFF, mk_row(16'hBEEF, 0), 1'b1);
      total++; if (o_full !== 1'b1) begin bad++; $display("FAIL rdwr_full got=%b want=1", o_full); end
      total++; if (o_overflow !== 1'b0) begin bad++; $display("FAIL rdwr_ovf got=%b want=0", o_overflow); end
      for (int r = 0; r < DEPTH; r++) begin
         total++; if (out !== m_out()) begin bad++; $display("FAIL rdwr_drain row=%0d got=%h want=%h", r, out, m_out()); end
         if (r == DEPTH - 1) begin
            total++; if (out !== mk_row(16'hBEEF, 0)) begin bad++; $display("FAIL rdwr_last got=%h want=%h", out, mk_row(16'hBEEF, 0)); end
         end
         tick(8'h00, '0, 1'b1);
      end
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rdwr_empty got=%b want=0", o_valid); end
   endtask

   task automatic test_empty_lane_rd();
      apply_reset();
      tick(8'hDF, mk_row(16'h0500, 1), 1'b0);
      tick(8'h00, '0, 1'b1);
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL lane5_valid got=%b want=0", o_valid); end
      total++; if (out !== '0) begin bad++; $display("FAIL lane5_out got=%h want=0", out); end
      tick(8'h20, mk_row(16'h0500, 1), 1'b0);
      total++; if (out !== mk_row(16'h0500, 1)) begin bad++; $display("FAIL lane5_row got=%h want=%h", out, mk_row(16'h0500, 1)); end
      tick(8'h00, '0, 1'b1);
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL lane5_pop got=%b want=0", o_valid); end
      tick(8'hFF, mk_row(16'h0600, 2), 1'b0);
      total++; if (out !== mk_row(16'h0600, 2)) begin bad++; $display("FAIL lane5_after got=%h want=%h", out, mk_row(16'h0600, 2)); end
      tick(8'h00, '0, 1'b1);
   endtask

   task automatic test_mid_reset();
      logic [COL*BW-1:0] row;
      apply_reset();
      for (int r = 0; r < 10; r++) tick(8'hFF, mk_row(BW'(r + 16'h0A00), 1), 1'b0);
      @(negedge clk);
      wr = '0; rd = 1'b0;
      #2 reset = 1'b0;
      #1;
      model_clear();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", o_valid); end
      total++; if (out !== '0) begin bad++; $display("FAIL midrst_out got=%h want=0", out); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", o_ready); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_release got=%b want=0", o_valid); end
      for (int k = 0; k < 2 * DEPTH + 5; k++) begin
         for (int i = 0; i < COL; i++) row[i*BW +: BW] = BW'($urandom);
         tick(8'hFF, row, 1'b0);
         total++; if (out !== row) begin bad++; $display("FAIL midrst_row k=%0d got=%h want=%h", k, out, row); end
         tick(8'h00, '0, 1'b1);
         total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_pop k=%0d got=%b want=0", k, o_valid); end
      end
   endtask

   task automatic test_random();
      logic [COL-1:0]    w;
      logic [COL*BW-1:0] d;
      logic              r;
      int                pw, pr;
      apply_reset();
      for (int c = 0; c < 1800; c++) begin
         case ((c / 150) % 3)
            0:       begin pw = 85; pr = 15; end
            1:       begin pw = 50; pr = 50; end
            default: begin pw = 20; pr = 90; end
         endcase
         for (int i = 0; i < COL; i++) begin
            w[i] = ($urandom_range(0, 99) < pw);
            d[i*BW +: BW] = BW'($urandom);
         end
         r = ($urandom_range(0, 99) < pr);
         tick(w, d, r);
         total++; if (o_valid !== m_valid()) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, o_valid, m_valid()); end
         total++; if (o_full !== m_full()) begin bad++; $display("FAIL rnd_full c=%0d got=%b want=%b", c, o_full, m_full()); end
         total++; if (o_ready !== !m_full()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, o_ready, !m_full()); end
         total++; if (o_overflow !== ovf_m) begin bad++; $display("FAIL rnd_ovf c=%0d got=%b want=%b", c, o_overflow, ovf_m); end
         total++; if (out !== m_out()) begin bad++; $display("FAIL rnd_out c=%0d got=%h want=%h", c, out, m_out()); end
      end
   endtask

   initial begin
      reset = 1'b0;
      wr    = '0;
      in    = '0;
      rd    = 1'b0;
      model_clear();
      test_reset();
      test_single_row();
      test_skew();
      test_fill_overflow();
      test_full_rdwr();
      test_empty_lane_rd();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
